// File: rtl/division_datapath.sv
// ---------------------------------------------------------------------------
// division_datapath
//
// Purpose:
//   Unsigned restoring shift-subtract divider datapath. There is no internal
//   sequencer. An external controller drives one-hot command strobes. One
//   division is: start, then WIDTH iterations of (shift, load...), then out.
//   When it finishes, Q holds the quotient and A holds the remainder.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset (overrides all commands)
//   start            capture divisor/dividend, clear A and e
//   load             conditional trial subtract of B from {e, A}
//   shift            17-bit (2*WIDTH+1) left shift of {e, A, Q}
//   out              copy A/Q into the result registers
//   divisor          divisor operand, sampled on start only
//   dividend         dividend operand, sampled on start only
//   e                carry bit above the partial remainder
//   quotient         working quotient register Q
//   remainder        working partial remainder register A
//   result_remainder remainder latched by out
//   result_quotient  quotient latched by out
// ---------------------------------------------------------------------------
module division_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             load,
    input  logic             shift,
    input  logic             out,
    input  logic [WIDTH-1:0] divisor,
    input  logic [WIDTH-1:0] dividend,
    output logic             e,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] result_remainder,
    output logic [WIDTH-1:0] result_quotient
);

    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             e_q, e_d;
    logic [WIDTH-1:0] resRem_q, resRem_d;
    logic [WIDTH-1:0] resQuo_q, resQuo_d;

    // The trial subtraction works on the (WIDTH+1)-bit partial remainder
    // {e, A}. After a shift this value is always below 2B, so at most one
    // subtraction can succeed. Repeated loads therefore have no further effect.
    logic [WIDTH:0] partialRem;
    logic [WIDTH:0] trialDiff;
    logic           trialOk;

    assign partialRem = {e_q, a_q};
    assign trialDiff  = partialRem - {1'b0, b_q};
    assign trialOk    = (partialRem >= {1'b0, b_q});

    // Next-state selection. Only the highest-priority strobe acts, in the
    // order start > out > shift > load. Reset is handled in the register
    // block. With no strobe asserted, every register holds its value.
    always_comb begin
        b_d      = b_q;
        a_d      = a_q;
        q_d      = q_q;
        e_d      = e_q;
        resRem_d = resRem_q;
        resQuo_d = resQuo_q;

        if (start) begin
            b_d = divisor;
            q_d = dividend;
            a_d = '0;
            e_d = 1'b0;
        end else if (out) begin
            resRem_d = a_q;
            resQuo_d = q_q;
        end else if (shift) begin
            {e_d, a_d, q_d} = {a_q, q_q, 1'b0};
        end else if (load) begin
            if (trialOk) begin
                {e_d, a_d} = trialDiff;
                q_d[0]     = 1'b1;
            end
        end
    end

    // State registers. A synchronous reset clears everything and abandons
    // any division that is in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_q      <= '0;
            a_q      <= '0;
            q_q      <= '0;
            e_q      <= 1'b0;
            resRem_q <= '0;
            resQuo_q <= '0;
        end else begin
            b_q      <= b_d;
            a_q      <= a_d;
            q_q      <= q_d;
            e_q      <= e_d;
            resRem_q <= resRem_d;
            resQuo_q <= resQuo_d;
        end
    end

    assign e                = e_q;
    assign quotient         = q_q;
    assign remainder        = a_q;
    assign result_remainder = resRem_q;
    assign result_quotient  = resQuo_q;

endmodule

// File: tb/tb_division_datapath.sv
// ---------------------------------------------------------------------------
// tb_division_datapath
//
// Self-checking bench for division_datapath. The stimulus process runs
// controller frames and pushes the expected results onto a queue. A separate
// monitor pops one entry each time an out command takes effect and compares
// the result registers against it.
// ---------------------------------------------------------------------------
module tb_division_datapath;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             load;
    logic             shift;
    logic             out;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] dividend;
    logic             e;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] result_remainder;
    logic [WIDTH-1:0] result_quotient;

    typedef struct packed {
        logic [WIDTH-1:0] quo;
        logic [WIDTH-1:0] rem;
        logic             eBit;
    } expect_t;

    expect_t sbQueue[$];
    int      errors    = 0;
    int      checks    = 0;
    int      outsIssued = 0;
    int      outsSeen  = 0;

    division_datapath #(.WIDTH(WIDTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .load             (load),
        .shift            (shift),
        .out              (out),
        .divisor          (divisor),
        .dividend         (dividend),
        .e                (e),
        .quotient         (quotient),
        .remainder        (remainder),
        .result_remainder (result_remainder),
        .result_quotient  (result_quotient)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain integer division. A zero divisor gives an
    // all-ones quotient and returns the dividend as the remainder.
    function automatic expect_t refDivide(input logic [WIDTH-1:0] dd,
                                          input logic [WIDTH-1:0] dv);
        expect_t r;
        if (dv == 0) begin
            r.quo = '1;
            r.rem = dd;
        end else begin
            r.quo = dd / dv;
            r.rem = dd % dv;
        end
        r.eBit = 1'b0;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of commands. Inputs change just after a falling edge
    // and are sampled at the next rising edge. The task returns at the
    // following falling edge, where it is safe to look at the outputs.
    task automatic applyStimulus(input logic r, input logic s, input logic sh,
                                 input logic ld, input logic o);
        rst   = r;
        start = s;
        shift = sh;
        load  = ld;
        out   = o;
        @(negedge clk);
    endtask

    task automatic startDiv(input logic [WIDTH-1:0] dd, input logic [WIDTH-1:0] dv,
                            input logic withShift, input logic withLoad);
        dividend = dd;
        divisor  = dv;
        applyStimulus(1'b0, 1'b1, withShift, withLoad, 1'b0);
    endtask

    task automatic iterate(input int nLoads, input bit scramble, input bit idles);
        for (int i = 0; i < WIDTH; i++) begin
            if (scramble) begin
                dividend = WIDTH'($urandom);
                divisor  = WIDTH'($urandom);
            end
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            for (int j = 0; j < nLoads; j++)
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (idles && ($urandom_range(0, 3) == 0))
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic finishOut(input expect_t exp);
        sbQueue.push_back(exp);
        outsIssued++;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic runFrame(input logic [WIDTH-1:0] dd, input logic [WIDTH-1:0] dv,
                            input int nLoads, input bit scramble, input bit idles);
        startDiv(dd, dv, 1'b0, 1'b0);
        iterate(nLoads, scramble, idles);
        finishOut(refDivide(dd, dv));
    endtask

    // Monitor: when an out command takes effect at a rising edge, compare
    // the latched results one half-cycle later against the next expectation.
    initial begin
        expect_t exp;
        forever begin
            @(posedge clk);
            if (out && !rst && !start) begin
                @(negedge clk);
                outsSeen++;
                if (sbQueue.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL scoreboard: out seen with no expectation queued");
                end else begin
                    exp = sbQueue.pop_front();
                    checkOutput("result_quotient", int'(result_quotient), int'(exp.quo));
                    checkOutput("result_remainder", int'(result_remainder), int'(exp.rem));
                    checkOutput("e_at_out", int'(e), int'(exp.eBit));
                end
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        logic [WIDTH-1:0] ddTab [5];
        logic [WIDTH-1:0] dvTab [5];
        logic [WIDTH-1:0] rdd;
        logic [WIDTH-1:0] rdv;

        ddTab = '{8'd7, 8'd2, 8'd8, 8'd32, 8'd66};
        dvTab = '{8'd2, 8'd2, 8'd10, 8'd4, 8'd5};

        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);

        // Reset with random strobes, then release with no command.
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        checkOutput("reset_quotient", int'(quotient), 0);
        checkOutput("reset_remainder", int'(remainder), 0);
        checkOutput("reset_e", int'(e), 0);
        checkOutput("reset_result_quotient", int'(result_quotient), 0);
        checkOutput("reset_result_remainder", int'(result_remainder), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_quotient", int'(quotient), 0);
        checkOutput("idle_remainder", int'(remainder), 0);
        checkOutput("idle_result_quotient", int'(result_quotient), 0);

        // Standard 26-cycle schedule with the directed pairs.
        for (int i = 0; i < 5; i++)
            runFrame(ddTab[i], dvTab[i], 2, 1'b0, 1'b0);

        // Boundary operands, including a zero divisor.
        runFrame(8'd255, 8'd1, 2, 1'b0, 1'b0);
        runFrame(8'd0, 8'd7, 2, 1'b0, 1'b0);
        runFrame(8'd5, 8'd255, 2, 1'b0, 1'b0);
        runFrame(8'd255, 8'd255, 2, 1'b0, 1'b0);
        runFrame(8'hA5, 8'd0, 2, 1'b0, 1'b0);

        // Results hold through idle cycles.
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_result_quotient", int'(result_quotient), 8'hFF);
        checkOutput("hold_result_remainder", int'(result_remainder), 8'hA5);

        // Operands change after start, and each iteration uses three loads.
        runFrame(8'd200, 8'd9, 3, 1'b1, 1'b0);
        runFrame(8'd66, 8'd5, 3, 1'b0, 1'b0);

        // start+shift+load together: only the initialisation happens.
        startDiv(8'd100, 8'd7, 1'b1, 1'b1);
        checkOutput("ssl_remainder", int'(remainder), 0);
        checkOutput("ssl_quotient", int'(quotient), 100);
        checkOutput("ssl_e", int'(e), 0);
        iterate(2, 1'b0, 1'b0);
        finishOut(refDivide(8'd100, 8'd7));

        // out+shift just after start: the results latch A=0, Q=dividend.
        // The shift is dropped, and the division still completes normally.
        startDiv(8'h3C, 8'd7, 1'b0, 1'b0);
        sbQueue.push_back('{quo: 8'h3C, rem: 8'd0, eBit: 1'b0});
        outsIssued++;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("os_quotient", int'(quotient), 8'h3C);
        checkOutput("os_remainder", int'(remainder), 0);
        iterate(2, 1'b0, 1'b0);
        finishOut(refDivide(8'h3C, 8'd7));

        // Reset at cycle 12 of a division, then a clean 66/5 frame.
        startDiv(8'd123, 8'd4, 1'b0, 1'b0);
        repeat (11) applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("midrst_quotient", int'(quotient), 0);
        checkOutput("midrst_remainder", int'(remainder), 0);
        checkOutput("midrst_result_quotient", int'(result_quotient), 0);
        runFrame(8'd66, 8'd5, 2, 1'b0, 1'b0);

        // Randomized frames with random load repeats, idles and operand churn.
        for (int i = 0; i < 40; i++) begin
            rdd = WIDTH'($urandom);
            rdv = ($urandom_range(0, 9) == 0) ? '0 : WIDTH'($urandom);
            runFrame(rdd, rdv, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'b1);
        end

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("scoreboard_drained", sbQueue.size(), 0);
        checkOutput("outs_observed", outsSeen, outsIssued);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/division_datapath.md
Name: division_datapath

Overview:
- 8-bit unsigned restoring shift-subtract divider datapath with no internal sequencer.
- An external controller drives four one-hot command strobes: start, shift, load, out.
- One division takes 8 iterations; each iteration is one shift command followed by load command(s).
- Live working registers and latched result registers are both exposed.

Parameters:
- WIDTH, 8, operand/quotient/remainder width. All widths below are stated for 8. The design must stay generic in WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  initialise a new division from divisor/dividend.
- load  input  1  conditional trial-subtract step.
- shift  input  1  left-shift step of {e, remainder, quotient}.
- out  input  1  copy working registers to the result registers.
- divisor  input  8  unsigned divisor, sampled on start only.
- dividend  input  8  unsigned dividend, sampled on start only.
- e  output  1  9th (carry) bit of the partial remainder.
- quotient  output  8  working quotient/dividend register Q.
- remainder  output  8  working partial-remainder register A.
- result_remainder  output  8  remainder latched by out.
- result_quotient  output  8  quotient latched by out.

Behaviour:
- Internal state: B (8-bit divisor copy), plus A, Q, e and the two result registers. All outputs come directly from registers.
- Reset: rst=1 at a rising edge clears A, Q, e, B, result_remainder and result_quotient to 0. Reset overrides every command, including mid-division; the division is abandoned.
- Command priority when several strobes are high in one cycle: rst > start > out > shift > load. Only the highest-priority command executes.
- No command asserted: all registers hold.
- start:
  - B <= divisor, Q <= dividend, A <= 0, e <= 0.
  - Inputs may change freely after the start edge.
- shift:
  - {e, A, Q} <= {A, Q, 1'b0}, i.e. a 17-bit left shift.
  - e receives A[7], and A[0] receives Q[7].
  - Q[0] becomes 0.
- load:
  - If {e, A} >= {0, B} (9-bit unsigned compare): {e, A} <= {e, A} - {0, B} and Q[0] <= 1.
  - Otherwise there is no change.
  - Load is idempotent within an iteration because {e,A} < 2B after a shift. Repeated load cycles before the next shift must not alter the result.
- out: result_remainder <= A, result_quotient <= Q. Working registers are unchanged. Results hold until the next out or rst.
- Required command sequence:
  - start (1 cycle).
  - Then 8 x [shift (1 cycle), load (>=1 cycle)].
  - Then out. Idle cycles are allowed anywhere.
  - After 8 iterations: Q = dividend / divisor, A = dividend % divisor, e = 0.
- Divide by zero (B=0): every load subtracts 0 and sets Q[0]. The final result is quotient = 0xFF, remainder = dividend. No error flag.
- Commands issued out of sequence (e.g. 9 shifts, or out mid-division) produce the defined register operations above with no protection.
- The standard controller schedule per 26-cycle frame:
  - cycle 0: start.
  - Shifts at cycles 1, 4, 7, 10, 13, 16, 19, 22.
  - Loads at the two cycles following each shift.
  - cycle 25: out.
  - Results are visible one edge after out.

Test Plan:
- rst held 2 cycles with random strobes -> all outputs 0; then rst released with no command -> outputs remain 0.
- Standard schedule with 7/2, 2/2, 8/10, 32/4, 66/5 -> result_quotient/result_remainder = 3/1, 1/0, 0/8, 8/0, 13/1. e=0 at each out.
- 255/1 -> 255/0; 0/7 -> 0/0; 5/255 -> 0/5; 255/255 -> 1/0.
- divisor=0, dividend=0xA5 -> quotient 0xFF, remainder 0xA5.
- Change dividend/divisor mid-division (after start) -> results reflect the values captured at start. Repeating load 3 cycles per iteration gives identical results.
- Simultaneous strobes:
  - start+shift+load in one cycle -> only the initialise effect.
  - out+shift -> results latch, A/Q unchanged.
  - rst asserted at cycle 12 of a division, then a new frame with 66/5 -> 13/1.
